uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and a fractional baud generator. It accepts words from the processor-side bus through a valid/ready handshake, buffers up to FIFO_DEPTH words, and serialises them LSB-first on uart_tx_o. The frame format is configurable: data width, optional parity, one or two stop bits. Buffered words go out back-to-back with no idle gap.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- BAUD, 115200: line rate; BAUD < CLK_HZ/2.
- DATA_BITS, 8: data bits per frame, 5..8.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: power of two, ≥ 2.
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_i  in  1  reset, synchronous, active-high.
- uart_wr_i  in  1  write strobe (valid).
- uart_dat_i  in  DATA_BITS  write data.
- uart_rdy_o  out  1  FIFO not full; a write is accepted only when high.
- uart_busy_o  out  1  FIFO non-empty or a frame is in progress.
- uart_level_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy.
- uart_ovf_o  out  1  sticky: a write was attempted while uart_rdy_o was low.
- uart_tx_o  out  1  serial line, idle high.

## Operation
- Reset values: uart_tx_o=1, uart_rdy_o=1, uart_busy_o=0, uart_level_o=0, uart_ovf_o=0. State is IDLE and FIFO pointers are 0.
- FIFO: push on uart_wr_i & uart_rdy_o. Pop when the FSM loads a frame. Read data is first-word-fall-through.
  - Simultaneous push and pop leave the level unchanged.
  - A write while full is dropped and sets uart_ovf_o. Only reset clears uart_ovf_o.
- Baud generator: a 32-bit accumulator, cleared on every frame load.
  - Each following cycle: acc += BAUD.
  - When the sum is ≥ CLK_HZ: subtract CLK_HZ and assert tick for that cycle.
  - The k-th bit boundary of a frame falls exactly ceil(k·CLK_HZ/BAUD) cycles after the load edge.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: when the FIFO is non-empty → pop, load shifter, go to START, drive uart_tx_o=0.
  - START: on tick → DATA, drive bit 0.
  - DATA: drive the shifter LSB. On tick, shift. After DATA_BITS ticks → PARITY if PARITY≠0, else STOP.
  - PARITY: drive ~^data for odd, ^data for even. On tick → STOP.
  - STOP: drive 1 for STOP_BITS bit periods. On the final tick:
    - FIFO non-empty → pop and go directly to START (line low on the same edge).
    - FIFO empty → IDLE.
- uart_busy_o = (state≠IDLE) | (level≠0).
- Reset mid-frame: on the next edge all outputs return to reset values and FIFO contents are discarded.

## Timing
- Write accepted at edge E while idle and empty:
  - uart_level_o=1 after E.
  - Pop at E+1: uart_tx_o falls and uart_level_o returns to 0 after E+1.
  - One cycle of write-to-line latency.
- Frame length = (1+DATA_BITS+(PARITY≠0)+STOP_BITS) bit periods.
  - Exact multiple of cycles when CLK_HZ/BAUD is an integer.
- uart_rdy_o, uart_level_o and uart_ovf_o are registered. uart_rdy_o reflects the post-edge level.
- Between back-to-back frames the line stays high for exactly STOP_BITS periods. There are no extra idle cycles.

## Test plan
All tests use CLK_HZ=8, BAUD=1 (8 cycles/bit), FIFO_DEPTH=4, except test 4.
1. 8N1, write 0xA5 at edge 0 → uart_tx_o low over cycles 1–8. Data bits 1,0,1,0,0,1,0,1, each 8 cycles. Stop bit high over cycles 73–80. uart_busy_o falls after edge 81.
2. 8N1, write 0x01..0x06 on six consecutive edges:
   - The first five are accepted and uart_rdy_o goes low after the fifth.
   - The sixth is dropped and uart_ovf_o=1.
   - Five frames are sent contiguously in 400 cycles and the line stays low only for start/zero bits.
3. DATA_BITS=7, PARITY=2, STOP_BITS=2, write 0x55 → bits 1010101, parity 0, two stop bits, frame 88 cycles. The same test with PARITY=1 gives parity bit 1.
4. CLK_HZ=100_000_000, BAUD=115200, 8N1:
   - The start bit lasts 869 cycles.
   - The stop bit ends 8681 cycles after the load edge.
   - Individual bit periods are 868 or 869 cycles.
5. Assert sys_rst_i for one cycle during the DATA state with 3 words queued → next edge: uart_tx_o=1, uart_level_o=0, uart_busy_o=0, uart_ovf_o=0. No further frames are sent.
6. FIFO full, uart_wr_i held high across the STOP→START pop edge:
   - The write is rejected at that edge because uart_rdy_o is still low, and uart_ovf_o is set.
   - The write is accepted on the next edge once uart_rdy_o=1, and uart_level_o returns to 4.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a first-word-fall-through transmit FIFO and a
// fractional (accumulator-based) baud generator; frames go out back-to-back.
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          uart_wr_i,
  input  logic [DATA_BITS-1:0]          uart_dat_i,
  output logic                          uart_rdy_o,
  output logic                          uart_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   uart_level_o,
  output logic                          uart_ovf_o,
  output logic                          uart_tx_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [LW-1:0]        level, level_nxt;
  logic                 rdy_q, ovf_q;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] rd_data;
  logic                 par_nxt;

  logic [31:0]          acc, acc_sum;
  logic                 tick;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 stop_last;
  logic                 tx_q;

  assign empty     = (level == '0);
  assign rd_data   = mem[rd_ptr];
  assign push      = uart_wr_i & rdy_q;
  assign par_nxt   = (PARITY == 1) ? ~^rd_data : ^rd_data;

  assign acc_sum   = acc + BAUD;
  assign tick      = (acc_sum >= CLK_HZ);
  assign stop_last = (state == S_STOP) && tick && (stop_cnt == 1'(STOP_BITS - 1));
  // A frame is loaded either from idle or straight off the final stop tick.
  assign pop       = !empty && ((state == S_IDLE) || stop_last);

  always_comb begin
    level_nxt = level;
    if (push && !pop)
      level_nxt = level + LW'(1);
    else if (pop && !push)
      level_nxt = level - LW'(1);
  end

  always_ff @(posedge sys_clk_i) begin
    if (push)
      mem[wr_ptr] <= uart_dat_i;
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      rdy_q  <= 1'b1;
      ovf_q  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      rdy_q <= (level_nxt != LW'(FIFO_DEPTH));
      if (uart_wr_i && !rdy_q)
        ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state    <= S_IDLE;
      tx_q     <= 1'b1;
      acc      <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
    end else begin
      acc <= tick ? (acc_sum - CLK_HZ) : acc_sum;
      case (state)
        S_IDLE: begin
          acc  <= '0;
          tx_q <= 1'b1;
        end
        S_START: begin
          if (tick) begin
            state   <= S_DATA;
            tx_q    <= shreg[0];
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (bit_cnt == 4'(DATA_BITS - 1)) begin
              if (PARITY != 0) begin
                state <= S_PARITY;
                tx_q  <= par_q;
              end else begin
                state    <= S_STOP;
                tx_q     <= 1'b1;
                stop_cnt <= 1'b0;
              end
            end else begin
              shreg   <= shreg >> 1;
              tx_q    <= shreg[1];
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state    <= S_STOP;
            tx_q     <= 1'b1;
            stop_cnt <= 1'b0;
          end
        end
        S_STOP: begin
          if (stop_last)
            state <= S_IDLE;
          else if (tick)
            stop_cnt <= stop_cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
      // Frame load overrides the per-state updates above (idle or stop->start).
      if (pop) begin
        state <= S_START;
        tx_q  <= 1'b0;
        shreg <= rd_data;
        par_q <= par_nxt;
        acc   <= '0;
      end
    end
  end

  assign uart_rdy_o   = rdy_q;
  assign uart_ovf_o   = ovf_q;
  assign uart_level_o = level;
  assign uart_tx_o    = tx_q;
  assign uart_busy_o  = (state != S_IDLE) || (level != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: 8N1, 7E2/7O2 and real-rate instances with a frame
// scoreboard on the 8N1 instance and cycle-exact line timing checks.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, rst_o;
  logic       wr_a, rdy_a, busy_a, ovf_a, tx_a;
  logic [7:0] dat_a;
  logic [2:0] lvl_a;
  logic       wr_bc;
  logic [6:0] dat_bc;
  logic       rdy_b, busy_b, ovf_b, tx_b;
  logic [2:0] lvl_b;
  logic       rdy_c, busy_c, ovf_c, tx_c;
  logic [2:0] lvl_c;
  logic       wr_d, rdy_d, busy_d, ovf_d, tx_d;
  logic [7:0] dat_d;
  logic [4:0] lvl_d;

  uart_tx_fifo #(.CLK_HZ(8), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_a (
    .sys_clk_i(clk), .sys_rst_i(rst_a), .uart_wr_i(wr_a), .uart_dat_i(dat_a),
    .uart_rdy_o(rdy_a), .uart_busy_o(busy_a), .uart_level_o(lvl_a), .uart_ovf_o(ovf_a), .uart_tx_o(tx_a));

  uart_tx_fifo #(.CLK_HZ(8), .BAUD(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u_b (
    .sys_clk_i(clk), .sys_rst_i(rst_o), .uart_wr_i(wr_bc), .uart_dat_i(dat_bc),
    .uart_rdy_o(rdy_b), .uart_busy_o(busy_b), .uart_level_o(lvl_b), .uart_ovf_o(ovf_b), .uart_tx_o(tx_b));

  uart_tx_fifo #(.CLK_HZ(8), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_c (
    .sys_clk_i(clk), .sys_rst_i(rst_o), .uart_wr_i(wr_bc), .uart_dat_i(dat_bc),
    .uart_rdy_o(rdy_c), .uart_busy_o(busy_c), .uart_level_o(lvl_c), .uart_ovf_o(ovf_c), .uart_tx_o(tx_c));

  uart_tx_fifo #(.CLK_HZ(100_000_000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d (
    .sys_clk_i(clk), .sys_rst_i(rst_o), .uart_wr_i(wr_d), .uart_dat_i(dat_d),
    .uart_rdy_o(rdy_d), .uart_busy_o(busy_d), .uart_level_o(lvl_d), .uart_ovf_o(ovf_d), .uart_tx_o(tx_d));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Expected line bits, index 0 = start bit, in transmission order.
  function automatic logic [31:0] frame_of(input logic [7:0] d, input int db, input int par, input int sb);
    logic [31:0] f;
    int          idx;
    logic        p;
    f   = '0;
    idx = 1;
    p   = 1'b0;
    for (int i = 0; i < db; i++) begin
      f[idx] = d[i];
      p      = p ^ d[i];
      idx++;
    end
    if (par != 0) begin
      f[idx] = (par == 1) ? ~p : p;
      idx++;
    end
    for (int i = 0; i < sb; i++) begin
      f[idx] = 1'b1;
      idx++;
    end
    return f;
  endfunction

  logic [31:0] exp_a[$];
  logic [31:0] exp_b[$];
  logic [31:0] exp_c[$];
  int          starts_a[$];
  int          frames_a = 0;

  // Scoreboard monitor for the 8N1 instance: samples first and last cycle of each bit.
  initial begin : mon_a
    logic [31:0] fst, lst, e;
    int          l;
    bit          abort;
    forever begin
      @(negedge clk);
      if (!rst_a && tx_a === 1'b0) begin
        l     = cyc;
        fst   = '0;
        lst   = '0;
        abort = 1'b0;
        fst[0] = tx_a;
        for (int j = 1; j < 80; j++) begin
          @(posedge clk);
          if (rst_a) abort = 1'b1;
          @(negedge clk);
          if (j % 8 == 0) fst[j/8] = tx_a;
          if (j % 8 == 7) lst[j/8] = tx_a;
        end
        if (!abort) begin
          frames_a++;
          starts_a.push_back(l);
          if (exp_a.size() == 0)
            chk("a_spurious_frame", fst, 32'h3FF);
          else begin
            e = exp_a.pop_front();
            chk("a_frame_first", fst, e);
            chk("a_frame_last", lst, e);
          end
        end
      end
    end
  end

  task automatic wait_idle_a(input string tag, input int limit, output int t);
    int i;
    i = 0;
    while (busy_a !== 1'b0 && i < limit) begin
      @(negedge clk);
      i++;
    end
    chk(tag, busy_a, 1'b0);
    t = cyc;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin : main
    int          e0, l2, l6, t, n0;
    logic [31:0] e, fb, lb, fc, lc;
    int          ntr, done, p;
    int          bnd [0:9];
    logic        prev;
    longint      ce;

    rst_a = 1'b1; rst_o = 1'b1;
    wr_a = 1'b0; dat_a = '0; wr_bc = 1'b0; dat_bc = '0; wr_d = 1'b0; dat_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_a, 1'b1);
    chk("rst_rdy", rdy_a, 1'b1);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_level", lvl_a, 0);
    chk("rst_ovf", ovf_a, 1'b0);
    chk("rst_others", {tx_b, rdy_b, busy_b, ovf_b, tx_c, rdy_c, busy_c, ovf_c, tx_d, rdy_d, busy_d, ovf_d},
        12'b1100_1100_1100);
    chk("rst_others_lvl", {lvl_b, lvl_c, lvl_d}, 0);
    rst_a = 1'b0; rst_o = 1'b0;
    @(negedge clk);

    // Single 0xA5 frame, 8N1
    wr_a = 1'b1; dat_a = 8'hA5;
    exp_a.push_back(frame_of(8'hA5, 8, 0, 1));
    @(negedge clk);
    wr_a = 1'b0; e0 = cyc;
    chk("t1_level_after_wr", lvl_a, 1);
    chk("t1_tx_before_load", tx_a, 1'b1);
    chk("t1_busy", busy_a, 1'b1);
    @(negedge clk);
    chk("t1_tx_start", tx_a, 1'b0);
    chk("t1_level_after_pop", lvl_a, 0);
    repeat (79) @(negedge clk);
    chk("t1_busy_e80", busy_a, 1'b1);
    @(negedge clk);
    chk("t1_busy_e81", busy_a, 1'b0);
    chk("t1_tx_idle", tx_a, 1'b1);
    chk("t1_cycles", cyc - e0, 81);
    chk("t1_frames", frames_a, 1);

    // Six back-to-back writes into a depth-4 FIFO
    l2 = 0;
    for (int k = 1; k <= 6; k++) begin
      wr_a = 1'b1; dat_a = 8'(k);
      if (k <= 5) exp_a.push_back(frame_of(8'(k), 8, 0, 1));
      @(negedge clk);
      if (k == 1) l2 = cyc + 1;
      if (k == 2) begin
        chk("t2_push_pop_level", lvl_a, 1);
        chk("t2_tx_start", tx_a, 1'b0);
      end
      if (k == 5) begin
        chk("t2_rdy_full", rdy_a, 1'b0);
        chk("t2_level_full", lvl_a, 4);
        chk("t2_no_ovf_yet", ovf_a, 1'b0);
      end
      if (k == 6) begin
        chk("t2_ovf", ovf_a, 1'b1);
        chk("t2_level_drop", lvl_a, 4);
      end
    end
    wr_a = 1'b0;
    wait_idle_a("t2_drain_timeout", 600, t);
    chk("t2_total_cycles", t - l2, 400);
    chk("t2_frames", frames_a, 6);
    if (starts_a.size() >= 6) begin
      chk("t2_first_start", starts_a[1], l2);
      for (int i = 2; i <= 5; i++)
        chk($sformatf("t2_gap%0d", i), starts_a[i] - starts_a[i-1], 80);
    end else
      chk("t2_start_count", starts_a.size(), 6);
    chk("t2_ovf_sticky", ovf_a, 1'b1);
    chk("t2_rdy_empty", rdy_a, 1'b1);

    // Reset mid-frame with 3 words queued
    for (int k = 1; k <= 4; k++) begin
      wr_a = 1'b1; dat_a = 8'(8'h10 + k);
      @(negedge clk);
    end
    wr_a = 1'b0;
    chk("t5_level_queued", lvl_a, 3);
    repeat (20) @(negedge clk);
    rst_a = 1'b1;
    exp_a.delete();
    @(negedge clk);
    rst_a = 1'b0;
    chk("t5_tx", tx_a, 1'b1);
    chk("t5_level", lvl_a, 0);
    chk("t5_busy", busy_a, 1'b0);
    chk("t5_ovf", ovf_a, 1'b0);
    chk("t5_rdy", rdy_a, 1'b1);
    n0 = frames_a;
    repeat (200) @(negedge clk);
    chk("t5_no_frames", frames_a, n0);
    chk("t5_still_idle", busy_a, 1'b0);

    // Write held across the stop->start pop edge while full
    l6 = 0;
    for (int k = 1; k <= 5; k++) begin
      wr_a = 1'b1; dat_a = 8'(8'h30 + k);
      exp_a.push_back(frame_of(8'(8'h30 + k), 8, 0, 1));
      @(negedge clk);
      if (k == 1) l6 = cyc + 1;
    end
    wr_a = 1'b0;
    chk("t6_level_full", lvl_a, 4);
    chk("t6_ovf_clear", ovf_a, 1'b0);
    n0 = frames_a;
    while (cyc < l6 + 79) @(negedge clk);
    wr_a = 1'b1; dat_a = 8'h77;
    chk("t6_rdy_before_pop", rdy_a, 1'b0);
    @(negedge clk);
    chk("t6_ovf_set", ovf_a, 1'b1);
    chk("t6_level_after_pop", lvl_a, 3);
    chk("t6_rdy_after_pop", rdy_a, 1'b1);
    chk("t6_tx_next_start", tx_a, 1'b0);
    exp_a.push_back(frame_of(8'h77, 8, 0, 1));
    @(negedge clk);
    wr_a = 1'b0;
    chk("t6_level_refill", lvl_a, 4);
    chk("t6_rdy_refill", rdy_a, 1'b0);
    wait_idle_a("t6_drain_timeout", 700, t);
    chk("t6_frames", frames_a - n0, 6);
    chk("a_queue_empty", exp_a.size(), 0);

    // 7E2 and 7O2 frames of 0x55
    wr_bc = 1'b1; dat_bc = 7'h55;
    exp_b.push_back(frame_of(8'h55, 7, 2, 2));
    exp_c.push_back(frame_of(8'h55, 7, 1, 2));
    @(negedge clk);
    wr_bc = 1'b0;
    chk("t3_level", lvl_b, 1);
    fb = '0; lb = '0; fc = '0; lc = '0;
    for (int j = 0; j < 88; j++) begin
      @(negedge clk);
      if (j % 8 == 0) begin fb[j/8] = tx_b; fc[j/8] = tx_c; end
      if (j % 8 == 7) begin lb[j/8] = tx_b; lc[j/8] = tx_c; end
      if (j == 87) chk("t3_busy_last_cycle", busy_b, 1'b1);
    end
    @(negedge clk);
    chk("t3_busy_b_end", busy_b, 1'b0);
    chk("t3_busy_c_end", busy_c, 1'b0);
    e = exp_b.pop_front();
    chk("t3_even_first", fb, e);
    chk("t3_even_last", lb, e);
    chk("t3_even_parity", fb[8], 1'b0);
    e = exp_c.pop_front();
    chk("t3_odd_first", fc, e);
    chk("t3_odd_last", lc, e);
    chk("t3_odd_parity", fc[8], 1'b1);

    // Fractional baud at 100 MHz / 115200; 0x55 toggles at every boundary
    wr_d = 1'b1; dat_d = 8'h55;
    @(negedge clk);
    wr_d = 1'b0;
    @(negedge clk);
    chk("t4_start", tx_d, 1'b0);
    for (int k = 0; k < 10; k++) bnd[k] = 0;
    prev = 1'b0; ntr = 0; done = 0;
    for (int c = 1; c <= 9000; c++) begin
      @(negedge clk);
      if (tx_d !== prev) begin
        ntr++;
        if (ntr <= 9) bnd[ntr] = c;
        prev = tx_d;
      end
      if (busy_d === 1'b0) begin
        done = c;
        break;
      end
    end
    chk("t4_transitions", ntr, 9);
    chk("t4_start_len", bnd[1], 869);
    chk("t4_stop_end", done, 8681);
    for (int k = 1; k <= 9; k++) begin
      ce = (longint'(k) * 64'd100_000_000 + 64'd115_199) / 64'd115_200;
      chk($sformatf("t4_boundary%0d", k), bnd[k], 32'(ce));
    end
    for (int k = 2; k <= 9; k++) begin
      p = bnd[k] - bnd[k-1];
      chk($sformatf("t4_period_ok%0d", k), (p == 868 || p == 869), 1'b1);
    end
    chk("t4_tx_idle", tx_d, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
